// File: rtl/kernel_run_sequencer.sv
// Run sequencer for an ap_ctrl_hs array kernel: load words into a local scratchpad, start the kernel,
// serve its two RAM ports, then drain the scratchpad back out. Optional RUN watchdog: SEQ_WATCHDOG_EN.
module kernel_run_sequencer #(
    parameter int ADDR_WID    = 5,
    parameter int DATA_WID    = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [63:0]         read_base,
    input  logic [63:0]         write_base,
    input  logic [63:0]         stride,
    input  logic [63:0]         num_words,
    input  logic                read_ready,
    input  logic [DATA_WID-1:0] read_data,
    input  logic                write_ready,
    output logic                read_enable,
    output logic [63:0]         read_addr,
    output logic                finish_read,
    output logic                write_enable,
    output logic [63:0]         write_addr,
    output logic [DATA_WID-1:0] write_data,
    output logic                finish_write,
    output logic                ap_start,
    input  logic                ap_done,
    input  logic [ADDR_WID-1:0] k_addr0,
    input  logic [ADDR_WID-1:0] k_addr1,
    input  logic                k_ce0,
    input  logic                k_ce1,
    input  logic                k_we0,
    input  logic                k_we1,
    input  logic [DATA_WID-1:0] k_d0,
    input  logic [DATA_WID-1:0] k_d1,
    output logic [DATA_WID-1:0] k_q0,
    output logic [DATA_WID-1:0] k_q1,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam logic [63:0] DEPTH = 64'(1) << ADDR_WID;

    typedef enum logic [3:0] {
        S_IDLE, S_LD_WAIT, S_LD_STEP, S_KICK, S_RUN,
        S_ST_SET, S_ST_WAIT, S_ST_STEP, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] cnt_q, cnt_d;
    logic [63:0] i_q, i_d;
    logic [63:0] j_q, j_d;
    logic [63:0] read_addr_q, read_addr_d;
    logic [63:0] write_addr_q, write_addr_d;
    logic        read_enable_q, read_enable_d;
    logic        write_enable_q, write_enable_d;
    logic        finish_read_q, finish_read_d;
    logic        finish_write_q, finish_write_d;
    logic        ap_start_q, ap_start_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic [DATA_WID-1:0] mem [0:(1<<ADDR_WID)-1];
    logic [DATA_WID-1:0] k_q0_q, k_q1_q, write_data_q;
    logic                ld_we;
    logic                st_rd;
    logic [ADDR_WID-1:0] st_rd_idx;
    logic                in_run;
    logic                k0_wr, k0_rd, k1_wr, k1_rd;

`ifdef SEQ_WATCHDOG_EN
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYC - 1);
    logic [31:0] wd_q, wd_d;
`else
    // RUN waits indefinitely for ap_done in this build.
    if (TIMEOUT_CYC < 1) begin : g_no_watchdog
    end
`endif

    assign in_run = (state_q == S_RUN);
    assign k0_wr  = in_run & k_ce0 & k_we0;
    assign k0_rd  = in_run & k_ce0 & ~k_we0;
    assign k1_wr  = in_run & k_ce1 & k_we1;
    assign k1_rd  = in_run & k_ce1 & ~k_we1;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        i_d            = i_q;
        j_d            = j_q;
        read_addr_d    = read_addr_q;
        write_addr_d   = write_addr_q;
        read_enable_d  = read_enable_q;
        write_enable_d = write_enable_q;
        finish_read_d  = 1'b0;
        finish_write_d = 1'b0;
        ap_start_d     = 1'b0;
        done_d         = done_q;
        error_d        = error_q;
        ld_we          = 1'b0;
        st_rd          = 1'b0;
        st_rd_idx      = '0;
`ifdef SEQ_WATCHDOG_EN
        wd_d           = wd_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cnt_d         = (num_words > DEPTH) ? DEPTH : num_words;
                    error_d       = (num_words > DEPTH);
                    done_d        = 1'b0;
                    i_d           = '0;
                    j_d           = '0;
                    read_addr_d   = read_base;
                    read_enable_d = (num_words != 64'd0);
                    state_d       = S_LD_WAIT;
                end
            end
            S_LD_WAIT: begin
                if (cnt_q == 64'd0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (read_ready) begin
                    ld_we   = 1'b1;
                    state_d = S_LD_STEP;
                end
            end
            S_LD_STEP: begin
                if (i_q + 64'd1 < cnt_q) begin
                    i_d           = i_q + 64'd1;
                    read_addr_d   = read_addr_q + stride;
                    finish_read_d = 1'b1;
                    state_d       = S_LD_WAIT;
                end else begin
                    read_enable_d = 1'b0;
                    ap_start_d    = 1'b1;
                    state_d       = S_KICK;
                end
            end
            S_KICK: begin
`ifdef SEQ_WATCHDOG_EN
                wd_d    = '0;
`endif
                state_d = S_RUN;
            end
            S_RUN: begin
                if (ap_done) begin
                    state_d = S_ST_SET;
                end
`ifdef SEQ_WATCHDOG_EN
                else if (wd_q == WD_LAST) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
`endif
            end
            S_ST_SET: begin
                write_enable_d = 1'b1;
                write_addr_d   = write_base;
                j_d            = '0;
                st_rd          = 1'b1;
                state_d        = S_ST_WAIT;
            end
            S_ST_WAIT: begin
                if (write_ready) state_d = S_ST_STEP;
            end
            S_ST_STEP: begin
                if (j_q + 64'd1 < cnt_q) begin
                    finish_write_d = 1'b1;
                    j_d            = j_q + 64'd1;
                    write_addr_d   = write_addr_q + stride;
                    st_rd          = 1'b1;
                    st_rd_idx      = ADDR_WID'(j_q + 64'd1);
                    state_d        = S_ST_WAIT;
                end else begin
                    write_enable_d = 1'b0;
                    done_d         = 1'b1;
                    state_d        = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            i_q            <= '0;
            j_q            <= '0;
            read_addr_q    <= '0;
            write_addr_q   <= '0;
            read_enable_q  <= 1'b0;
            write_enable_q <= 1'b0;
            finish_read_q  <= 1'b0;
            finish_write_q <= 1'b0;
            ap_start_q     <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            i_q            <= i_d;
            j_q            <= j_d;
            read_addr_q    <= read_addr_d;
            write_addr_q   <= write_addr_d;
            read_enable_q  <= read_enable_d;
            write_enable_q <= write_enable_d;
            finish_read_q  <= finish_read_d;
            finish_write_q <= finish_write_d;
            ap_start_q     <= ap_start_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end
`endif

    // Port 1 is written last so it wins a same-address collision with port 0.
    always_ff @(posedge clk) begin
        if (ld_we) mem[i_q[ADDR_WID-1:0]] <= read_data;
        if (k0_wr) mem[k_addr0] <= k_d0;
        if (k1_wr) mem[k_addr1] <= k_d1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q0_q       <= '0;
            k_q1_q       <= '0;
            write_data_q <= '0;
        end else begin
            if (k0_rd) k_q0_q <= mem[k_addr0];
            if (k1_rd) k_q1_q <= mem[k_addr1];
            if (st_rd) write_data_q <= mem[st_rd_idx];
        end
    end

    assign read_enable  = read_enable_q;
    assign read_addr    = read_addr_q;
    assign finish_read  = finish_read_q;
    assign write_enable = write_enable_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;
    assign finish_write = finish_write_q;
    assign ap_start     = ap_start_q;
    assign k_q0         = k_q0_q;
    assign k_q1         = k_q1_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = done_q;
    assign error        = error_q;

endmodule
